usb_in_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single usb_cdc IN byte stream (device->host)

---
 rtl/usb_in_arbiter_pkg.sv | 6 +
 rtl/usb_in_arbiter_rr_picker.sv | 22 ++
 rtl/usb_in_arbiter.sv | 100 ++++++++++
 tb/tb_usb_in_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_in_arbiter_pkg.sv
// usb_in_arbiter_pkg: state encoding and counter widths shared by the IN-stream arbiter
package usb_in_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
  localparam int BURST_CW = 8;
  localparam int IDLE_CW = 4;
endpackage

// File: rtl/usb_in_arbiter_rr_picker.sv
// rr_picker: one-hot pick of the first set request above ptr, wrapping around
module rr_picker #(
  parameter int N = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic          any
);
  logic [PW-1:0] idx;
  // Walk farthest-to-nearest so the candidate closest after ptr is written last
  always_comb begin
    onehot = '0;
    idx = '0;
    for (int i = N; i >= 1; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx]) onehot = N'(1) << idx;
    end
  end
  assign any = |req;
endmodule

// File: rtl/usb_in_arbiter.sv
// usb_in_arbiter: burst-based round-robin sharing of the usb_cdc IN byte stream.
// Define USB_IN_ARB_STATS_EN to add stat_cnt_o, saturating per-requester transfer counters.
module usb_in_arbiter
  import usb_in_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_BURST = 8,
  parameter int IDLE_HOLD = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [NUM_REQ*8-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           in_data_o,
  output logic                 in_valid_o,
  input  logic                 in_ready_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o
`ifdef USB_IN_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] stat_cnt_o
`endif
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n, win;
  logic [PW-1:0] ptr, ptr_n, win_idx;
  logic [BURST_CW-1:0] burst_cnt, burst_n;
  logic [IDLE_CW-1:0] idle_cnt, idle_n;
  logic any, xfer, rel;
  rr_picker #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req(req_valid_i),
    .ptr(ptr),
    .onehot(win),
    .any(any)
  );
  always_comb begin
    in_data_o = '0;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_o[k]) in_data_o = req_data_i[8*k +: 8];
      if (win[k]) win_idx = PW'(k);
    end
  end
  // Gating with rstn_i keeps a byte in flight during reset from being acknowledged
  assign in_valid_o = rstn_i & |(req_valid_i & grant_o);
  assign req_ready_o = grant_o & {NUM_REQ{in_ready_i & rstn_i}};
  assign xfer = in_valid_o & in_ready_i;
  assign rel = (xfer && burst_cnt == BURST_CW'(MAX_BURST - 1)) ||
               (!in_valid_o && idle_cnt == IDLE_CW'(IDLE_HOLD - 1));
  assign busy_o = state == ST_GRANT;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= ST_IDLE;
      grant_o <= '0;
      ptr <= PW'(NUM_REQ - 1);
      burst_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state <= state_n;
      grant_o <= grant_n;
      ptr <= ptr_n;
      burst_cnt <= burst_n;
      idle_cnt <= idle_n;
    end
  end
  always_comb begin
    state_n = state;
    grant_n = grant_o;
    ptr_n = ptr;
    burst_n = burst_cnt;
    idle_n = idle_cnt;
    if (state == ST_IDLE) begin
      if (any) begin
        state_n = ST_GRANT;
        grant_n = win;
        ptr_n = win_idx;
      end
    end else if (rel) begin
      state_n = ST_IDLE;
      grant_n = '0;
      burst_n = '0;
      idle_n = '0;
    end else begin
      burst_n = burst_cnt + BURST_CW'(xfer);
      idle_n = in_valid_o ? '0 : idle_cnt + 1'b1;
    end
  end
`ifdef USB_IN_ARB_STATS_EN
  for (genvar s = 0; s < NUM_REQ; s++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk_i) begin
      if (!rstn_i) cnt <= '0;
      else if (xfer && grant_o[s] && cnt != 16'hFFFF) cnt <= cnt + 1'b1;
    end
    assign stat_cnt_o[16*s +: 16] = cnt;
  end
`endif
endmodule

// File: tb/tb_usb_in_arbiter.sv
// tb_usb_in_arbiter: scoreboarded byte-stream checks plus a combinational datapath vector table
module tb_usb_in_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [15:0] req_data;
  logic [1:0] req_valid, req_ready, grant;
  logic [7:0] in_data;
  logic in_valid, in_ready, busy;
`ifdef USB_IN_ARB_STATS_EN
  logic [31:0] stat_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] src_q[2][$];
  logic [7:0] exp_q[2][$];
  bit en[2];
  bit pop[2];
  bit tog;
  logic [1:0] gl[$];
  bit xl[$];
  logic [1:0] p_grant[$];
  int p_len[$], p_dur[$], p_gap[$];

  typedef struct {
    logic [1:0] v;
    logic       r;
    logic [7:0] d0, d1;
    logic       ev;
    logic [1:0] er;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  usb_in_arbiter dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .req_data_i(req_data),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .in_data_o(in_data),
    .in_valid_o(in_valid),
    .in_ready_i(in_ready),
    .grant_o(grant),
    .busy_o(busy)
`ifdef USB_IN_ARB_STATS_EN
    ,
    .stat_cnt_o(stat_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input int k, input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'(k * 128 + i % 128);
      src_q[k].push_back(b);
      exp_q[k].push_back(b);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = en[k] && src_q[k].size() > 0;
      req_data[8*k +: 8] = src_q[k].size() > 0 ? src_q[k][0] : 8'h00;
    end
    if (tog) in_ready = ~in_ready;
  endtask

  task automatic mon();
    bit x;
    int o;
    x = in_valid && in_ready;
    gl.push_back(grant);
    xl.push_back(x);
    chk("ready_mirror", {30'd0, req_ready}, {30'd0, rstn ? (grant & {2{in_ready}}) : 2'b00});
    chk("valid_mux", {31'd0, in_valid}, {31'd0, rstn && |(req_valid & grant)});
    for (int k = 0; k < 2; k++) pop[k] = req_valid[k] && req_ready[k];
    if (x) begin
      o = int'(in_data[7]);
      chk("xfer_owner", {30'd0, grant}, {30'd0, 2'b01 << o});
      if (exp_q[o].size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL xfer_data: got 0x%0h, required no transfer (scoreboard empty)", in_data);
      end else chk("xfer_data", {24'd0, in_data}, {24'd0, exp_q[o].pop_front()});
    end
  endtask

  task automatic cyc();
    drive();
    @(negedge clk);
    mon();
    @(posedge clk);
    for (int k = 0; k < 2; k++) if (pop[k]) void'(src_q[k].pop_front());
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    en = '{0, 0};
    tog = 1'b0;
    in_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    repeat (2) cyc();
    rstn = 1'b1;
    gl.delete();
    xl.delete();
  endtask

  task automatic analyze();
    int gap;
    gap = 0;
    p_grant.delete();
    p_len.delete();
    p_dur.delete();
    p_gap.delete();
    for (int i = 0; i < gl.size(); i++) begin
      if (gl[i] == 2'b00) begin
        gap++;
        continue;
      end
      if (i == 0 || gl[i] != gl[i-1]) begin
        p_grant.push_back(gl[i]);
        p_len.push_back(0);
        p_dur.push_back(0);
        p_gap.push_back(gap);
      end
      p_len[p_len.size()-1] += int'(xl[i]);
      p_dur[p_dur.size()-1] += 1;
      gap = 0;
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((src_q[0].size() > 0 || src_q[1].size() > 0) && i < budget) begin
      cyc();
      i++;
    end
    chk("drain_in_budget", {31'd0, i < budget}, 32'd1);
    repeat (6) cyc();
    chk("scoreboard_empty", exp_q[0].size() + exp_q[1].size(), 32'd0);
    analyze();
  endtask

  task automatic wait_grant(input logic [1:0] g, input int budget);
    int i;
    i = 0;
    do begin
      cyc();
      i++;
    end while (gl[gl.size()-1] != g && i < budget);
    chk("grant_wait", {30'd0, gl[gl.size()-1]}, {30'd0, g});
  endtask

  task automatic chk_period(input int i, input logic [1:0] g, input int len, input int gap);
    if (i >= p_grant.size()) begin
      n_chk++;
      n_fail++;
      $display("FAIL period_missing: got %0d grant periods, required more than %0d", p_grant.size(), i);
    end else begin
      chk("period_grant", {30'd0, p_grant[i]}, {30'd0, g});
      chk("period_bytes", p_len[i], len);
      if (gap >= 0) chk("dead_cycles", p_gap[i], gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nx, i;
    tbl[0] = '{2'b11, 1'b1, 8'hAA, 8'h55, 1'b1, 2'b10, 8'h55};
    tbl[1] = '{2'b10, 1'b0, 8'hAA, 8'h56, 1'b1, 2'b00, 8'h56};
    tbl[2] = '{2'b01, 1'b1, 8'hAB, 8'h57, 1'b0, 2'b10, 8'h57};
    tbl[3] = '{2'b00, 1'b1, 8'h00, 8'hFF, 1'b0, 2'b10, 8'hFF};
    tbl[4] = '{2'b11, 1'b0, 8'h12, 8'h34, 1'b1, 2'b00, 8'h34};
    tbl[5] = '{2'b01, 1'b0, 8'h77, 8'h88, 1'b0, 2'b00, 8'h88};
    req_valid = '0;
    req_data = '0;
    in_ready = 1'b0;
    tog = 1'b0;

    // reset held two cycles with every requester valid
    rstn = 1'b0;
    load(0, 2);
    load(1, 2);
    en = '{1, 1};
    in_ready = 1'b1;
    repeat (2) cyc();
    chk("reset_grant", {30'd0, grant}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_in_valid", {31'd0, in_valid}, 32'd0);
    chk("reset_req_ready", {30'd0, req_ready}, 32'd0);
    chk("reset_in_data", {24'd0, in_data}, 32'd0);

    // lone source, 20 bytes: bursts 8, 8, 4 separated by one dead cycle
    do_reset();
    in_ready = 1'b1;
    load(0, 20);
    en[0] = 1;
    drain(100);
    chk("single_periods", p_grant.size(), 32'd3);
    chk_period(0, 2'b01, 8, -1);
    chk_period(1, 2'b01, 8, 1);
    chk_period(2, 2'b01, 4, 1);
`ifdef USB_IN_ARB_STATS_EN
    chk("stat0_single", {16'd0, stat_cnt[15:0]}, 32'd20);
    chk("stat1_single", {16'd0, stat_cnt[31:16]}, 32'd0);
`endif

    // contention: strict alternation, req0 first after reset
    do_reset();
    in_ready = 1'b1;
    load(0, 24);
    load(1, 24);
    en = '{1, 1};
    drain(200);
    chk("contention_periods", p_grant.size(), 32'd6);
    for (int k = 0; k < 6; k++) chk_period(k, (k % 2) ? 2'b10 : 2'b01, 8, (k == 0) ? -1 : 1);
`ifdef USB_IN_ARB_STATS_EN
    chk("stat0_contention", {16'd0, stat_cnt[15:0]}, 32'd24);
    chk("stat1_contention", {16'd0, stat_cnt[31:16]}, 32'd24);
`endif

    // backpressure: in_ready toggles every cycle
    do_reset();
    in_ready = 1'b1;
    tog = 1'b1;
    load(0, 16);
    load(1, 16);
    en = '{1, 1};
    drain(200);
    chk("backpressure_periods", p_grant.size(), 32'd4);
    for (int k = 0; k < 4; k++) chk_period(k, (k % 2) ? 2'b10 : 2'b01, 8, (k == 0) ? -1 : 1);

    // idle release: req1 sends 3 bytes then goes quiet while req0 waits
    do_reset();
    in_ready = 1'b1;
    load(1, 3);
    load(0, 10);
    en[1] = 1;
    wait_grant(2'b10, 10);
    en[0] = 1;
    drain(100);
    chk("idle_periods", p_grant.size(), 32'd3);
    chk_period(0, 2'b10, 3, -1);
    if (p_dur.size() > 0) chk("idle_hold_cycles", p_dur[0], 32'd7);
    chk_period(1, 2'b01, 8, 1);
    chk_period(2, 2'b01, 2, 1);

    // reset after 5 bytes of a burst
    do_reset();
    in_ready = 1'b1;
    load(0, 20);
    en[0] = 1;
    nx = 0;
    i = 0;
    while (nx < 5 && i < 50) begin
      cyc();
      nx += int'(xl[xl.size()-1]);
      i++;
    end
    chk("midburst_bytes", nx, 32'd5);
`ifdef USB_IN_ARB_STATS_EN
    chk("stat0_before_reset", {16'd0, stat_cnt[15:0]}, 32'd5);
`endif
    rstn = 1'b0;
    cyc();
    chk("midreset_grant", {30'd0, grant}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_inflight_kept", src_q[0].size(), 32'd15);
`ifdef USB_IN_ARB_STATS_EN
    chk("stat_after_reset", stat_cnt, 32'd0);
`endif
    rstn = 1'b1;

    // combinational datapath vectors while req1 holds the grant
    do_reset();
    in_ready = 1'b1;
    load(1, 4);
    en[1] = 1;
    wait_grant(2'b10, 10);
    for (int k = 0; k < 6; k++) begin
      req_valid = tbl[k].v;
      req_data = {tbl[k].d1, tbl[k].d0};
      in_ready = tbl[k].r;
      #1;
      chk("vec_in_valid", {31'd0, in_valid}, {31'd0, tbl[k].ev});
      chk("vec_req_ready", {30'd0, req_ready}, {30'd0, tbl[k].er});
      chk("vec_in_data", {24'd0, in_data}, {24'd0, tbl[k].ed});
      chk("vec_grant_held", {30'd0, grant}, 32'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
